uart_alu_ctrl: RTL and testbench

//  Packet controller between the uart_rx/uart_tx AXI-stream byte ports and a 32-bit ALU.
//  - Parses a 4-byte header from the RX stream and dispatches the packet.
//  - Echo packets loop their payload back to TX.
//  - ALU packets: assembles payload into 32-bit operands, streams them to the ALU,

---
 rtl/uart_alu_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl.sv
// Packet controller between UART byte streams and a 32-bit ALU.
// Parses a 4-byte header, then echoes payload or runs ALU operand/result transfers.
module uart_alu_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_tdata_i,
    input  logic        rx_tvalid_i,
    output logic        rx_tready_o,
    output logic [7:0]  tx_tdata_o,
    output logic        tx_tvalid_o,
    input  logic        tx_tready_i,
    output logic [1:0]  alu_op_o,
    output logic [31:0] alu_opnd_o,
    output logic        alu_opnd_valid_o,
    output logic        alu_opnd_last_o,
    input  logic        alu_opnd_ready_i,
    input  logic [31:0] alu_res_i,
    input  logic        alu_res_valid_i,
    output logic        alu_res_ready_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'h10;
    localparam logic [7:0] OP_MUL  = 8'h11;
    localparam logic [7:0] OP_DIV  = 8'h12;

    typedef enum logic [2:0] {
        S_HDR,
        S_ECHO,
        S_COLLECT,
        S_ISSUE,
        S_WAIT_RES,
        S_SEND,
        S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [7:0]  opc_q, opc_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] rem_q, rem_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] res_q, res_d;
    logic [7:0]  txb_q, txb_d;
    logic        txv_q, txv_d;
    logic [1:0]  alu_op_q, alu_op_d;
    logic        err_q, err_d;

    logic        rx_fire;
    logic [15:0] len_w;
    logic [15:0] rem_w;
    logic        is_alu;
    logic        alu_len_ok;
    logic [7:0]  res_byte;

    assign rx_fire    = rx_tvalid_i & rx_tready_o;
    assign len_w      = {rx_tdata_i, len_lo_q};
    assign rem_w      = len_w - 16'd4;
    assign is_alu     = (opc_q == OP_ADD) | (opc_q == OP_MUL) | (opc_q == OP_DIV);
    assign alu_len_ok = (len_w >= 16'd8) & (len_w[1:0] == 2'b00);

    always_comb begin
        res_byte = res_q[7:0];
        case (idx_q)
            2'd1:    res_byte = res_q[15:8];
            2'd2:    res_byte = res_q[23:16];
            2'd3:    res_byte = res_q[31:24];
            default: res_byte = res_q[7:0];
        endcase
    end

    // The echo path stops accepting once its payload is consumed so the
    // following packet's opcode is left for the header parser.
    assign rx_tready_o = (state_q == S_HDR) | (state_q == S_COLLECT) |
                         (state_q == S_DRAIN) |
                         ((state_q == S_ECHO) & (rem_q != 16'd0) &
                          (~txv_q | tx_tready_i));

    assign tx_tvalid_o      = (state_q == S_SEND) | txv_q;
    assign tx_tdata_o       = (state_q == S_SEND) ? res_byte : txb_q;
    assign alu_op_o         = alu_op_q;
    assign alu_opnd_o       = opnd_q;
    assign alu_opnd_valid_o = (state_q == S_ISSUE);
    assign alu_opnd_last_o  = (state_q == S_ISSUE) & (rem_q == 16'd0);
    assign alu_res_ready_o  = (state_q == S_WAIT_RES);
    assign busy_o           = ~((state_q == S_HDR) & (hdr_cnt_q == 2'd0));
    assign err_o            = err_q;

    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        opc_d     = opc_q;
        len_lo_d  = len_lo_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        opnd_d    = opnd_q;
        res_d     = res_q;
        txb_d     = txb_q;
        txv_d     = txv_q;
        alu_op_d  = alu_op_q;
        err_d     = 1'b0;
        case (state_q)
            S_HDR: begin
                if (rx_fire) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    case (hdr_cnt_q)
                        2'd0: opc_d = rx_tdata_i;
                        2'd2: len_lo_d = rx_tdata_i;
                        2'd3: begin
                            rem_d = rem_w;
                            idx_d = 2'd0;
                            if (opc_q == OP_ECHO) begin
                                state_d = (rem_w != 16'd0) ? S_ECHO : S_HDR;
                            end else if (is_alu & alu_len_ok) begin
                                state_d  = S_COLLECT;
                                alu_op_d = opc_q[1:0];
                            end else begin
                                err_d   = 1'b1;
                                state_d = (len_w > 16'd4) ? S_DRAIN : S_HDR;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_ECHO: begin
                if (rx_fire) begin
                    txb_d = rx_tdata_i;
                    txv_d = 1'b1;
                    rem_d = rem_q - 16'd1;
                end else if (txv_q & tx_tready_i) begin
                    txv_d = 1'b0;
                end
                if ((rem_q == 16'd0) & (~txv_q | tx_tready_i)) begin
                    state_d = S_HDR;
                end
            end
            S_COLLECT: begin
                if (rx_fire) begin
                    opnd_d = {rx_tdata_i, opnd_q[31:8]};
                    rem_d  = rem_q - 16'd1;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (alu_opnd_ready_i) begin
                    state_d = (rem_q == 16'd0) ? S_WAIT_RES : S_COLLECT;
                end
            end
            S_WAIT_RES: begin
                if (alu_res_valid_i) begin
                    res_d   = alu_res_i;
                    idx_d   = 2'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_tready_i) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_HDR;
                    end
                end
            end
            S_DRAIN: begin
                if (rx_fire) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = S_HDR;
                    end
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_HDR;
            hdr_cnt_q <= 2'd0;
            opc_q     <= 8'd0;
            len_lo_q  <= 8'd0;
            rem_q     <= 16'd0;
            idx_q     <= 2'd0;
            opnd_q    <= 32'd0;
            res_q     <= 32'd0;
            txb_q     <= 8'd0;
            txv_q     <= 1'b0;
            alu_op_q  <= 2'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            opc_q     <= opc_d;
            len_lo_q  <= len_lo_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            opnd_q    <= opnd_d;
            res_q     <= res_d;
            txb_q     <= txb_d;
            txv_q     <= txv_d;
            alu_op_q  <= alu_op_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with a packet-level expectation model.
// A negedge monitor scores every TX byte and ALU operand against the model queues.
module tb_uart_alu_ctrl;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [7:0]  rx_tdata;
    logic        rx_tvalid;
    logic        rx_tready_o;
    logic [7:0]  tx_tdata_o;
    logic        tx_tvalid_o;
    logic        tx_tready;
    logic [1:0]  alu_op_o;
    logic [31:0] alu_opnd_o;
    logic        alu_opnd_valid_o;
    logic        alu_opnd_last_o;
    logic        alu_opnd_ready;
    logic [31:0] alu_res;
    logic        alu_res_valid;
    logic        alu_res_ready_o;
    logic        busy_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;
    int exp_err = 0;
    int err_seen = 0;
    logic [7:0]  exp_tx[$];
    logic [32:0] exp_opnd[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'd0;

    always #5 clk = ~clk;

    uart_alu_ctrl dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .rx_tdata_i       (rx_tdata),
        .rx_tvalid_i      (rx_tvalid),
        .rx_tready_o      (rx_tready_o),
        .tx_tdata_o       (tx_tdata_o),
        .tx_tvalid_o      (tx_tvalid_o),
        .tx_tready_i      (tx_tready),
        .alu_op_o         (alu_op_o),
        .alu_opnd_o       (alu_opnd_o),
        .alu_opnd_valid_o (alu_opnd_valid_o),
        .alu_opnd_last_o  (alu_opnd_last_o),
        .alu_opnd_ready_i (alu_opnd_ready),
        .alu_res_i        (alu_res),
        .alu_res_valid_i  (alu_res_valid),
        .alu_res_ready_o  (alu_res_ready_o),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Expectations derived from packet contents alone.
    task automatic model_packet(input bq_t p, output logic [31:0] res);
        logic [15:0] len;
        logic [31:0] w;
        int rem;
        len = {p[3], p[2]};
        rem = int'(len) - 4;
        res = 32'd0;
        if (p[0] == 8'hEC) begin
            for (int i = 4; i < int'(len); i++) exp_tx.push_back(p[i]);
        end else if (p[0] >= 8'h10 && p[0] <= 8'h12 && len >= 16'd8 &&
                     len % 16'd4 == 16'd0) begin
            for (int k = 0; k < rem / 4; k++) begin
                w = {p[4*k+7], p[4*k+6], p[4*k+5], p[4*k+4]};
                exp_opnd.push_back({k == rem / 4 - 1, w});
                if (k == 0) res = w;
                else if (p[0] == 8'h10) res = res + w;
                else if (p[0] == 8'h11) res = res * w;
                else res = (w == 0) ? 32'hFFFF_FFFF : res / w;
            end
            for (int i = 0; i < 4; i++) exp_tx.push_back(res[8*i +: 8]);
        end else begin
            exp_err++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_ni) begin
            if (prev_stall) begin
                check("tx_hold_valid", tx_tvalid_o, 1);
                check("tx_hold_data", tx_tdata_o, prev_data);
            end
            prev_stall = tx_tvalid_o & ~tx_tready;
            prev_data  = tx_tdata_o;
            if (tx_tvalid_o & tx_tready) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_extra: got %0h expected none", tx_tdata_o);
                end else begin
                    check("tx_byte", tx_tdata_o, exp_tx.pop_front());
                end
            end
            if (alu_opnd_valid_o & alu_opnd_ready) begin
                if (exp_opnd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL opnd_extra: got %0h expected none", alu_opnd_o);
                end else begin
                    check("opnd", {alu_opnd_last_o, alu_opnd_o}, exp_opnd.pop_front());
                end
            end
            if (alu_res_valid & alu_res_ready_o)
                check("res_early", exp_opnd.size(), 0);
            if (err_o) err_seen++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        rx_tdata  = b;
        rx_tvalid = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            acc = rx_tready_o;
            @(posedge clk);
            #1;
            if (acc) begin
                rx_tvalid = 1'b0;
                return;
            end
        end
        rx_tvalid = 1'b0;
        fail_now("rx_timeout");
    endtask

    task automatic send_pkt(input bq_t p);
        foreach (p[i]) send_byte(p[i]);
    endtask

    task automatic wait_res_hs(input logic [1:0] op);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (alu_res_ready_o & alu_res_valid) begin
                check("alu_op", alu_op_o, op);
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        alu_res_valid = 1'b0;
        if (!got) fail_now("res_timeout");
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 3000; n++) begin
            if (exp_tx.size() == 0 && exp_opnd.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check({name, "_drained"}, exp_tx.size() + exp_opnd.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_err_count"}, err_seen, exp_err);
        check({name, "_idle"}, busy_o, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rx_tready"}, rx_tready_o, 1);
        check({name, "_tx"}, {tx_tvalid_o, tx_tdata_o}, 0);
        check({name, "_alu"}, {alu_opnd_valid_o, alu_opnd_last_o,
                               alu_res_ready_o, alu_op_o}, 0);
        check({name, "_opnd"}, alu_opnd_o, 0);
        check({name, "_busy_err"}, {busy_o, err_o}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bq_t p;
        logic [31:0] r;
        rst_ni         = 1'b0;
        rx_tdata       = 8'd0;
        rx_tvalid      = 1'b0;
        tx_tready      = 1'b1;
        alu_opnd_ready = 1'b1;
        alu_res        = 32'd0;
        alu_res_valid  = 1'b0;
        #22;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        p = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        model_packet(p, r);
        check("pin_echo_len", exp_tx.size(), 3);
        check("pin_echo_bytes", {exp_tx[0], exp_tx[1], exp_tx[2]}, 24'h414243);
        for (int i = 0; i < 4; i++) send_byte(p[i]);
        for (int i = 4; i < 7; i++) begin
            send_byte(p[i]);
            @(negedge clk);
            check("echo_lat_valid", tx_tvalid_o, 1);
            check("echo_lat_data", tx_tdata_o, p[i]);
            @(posedge clk);
            #1;
        end
        wait_drain("echo");

        p = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'h02, 8'h00, 8'h00, 8'h00};
        model_packet(p, r);
        check("pin_add_res", r, 32'h3);
        check("pin_add_opnds", {exp_opnd[0], exp_opnd[1]},
              {33'h0_0000_0001, 33'h1_0000_0002});
        alu_res       = r;
        alu_res_valid = 1'b1;
        send_pkt(p);
        wait_res_hs(2'd0);
        wait_drain("add");

        p = '{8'h11, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        model_packet(p, r);
        send_pkt(p);
        wait_drain("badlen");
        p = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        model_packet(p, r);
        send_pkt(p);
        wait_drain("after_drain");

        p = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
              8'h00, 8'h00, 8'h00, 8'h00};
        model_packet(p, r);
        check("pin_bp_res", r, 32'hDEAD_BEEF);
        tx_tready     = 1'b0;
        alu_res       = r;
        alu_res_valid = 1'b1;
        send_pkt(p);
        wait_res_hs(2'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (tx_tvalid_o) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (seen) check("bp_first_byte", tx_tdata_o, 8'hEF);
            else fail_now("bp_tx_timeout");
        end
        repeat (20) @(posedge clk);
        #1;
        tx_tready = 1'b1;
        wait_drain("backpressure");

        p = '{8'h12, 8'h00, 8'h0C, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00,
              8'h05, 8'h00, 8'h00, 8'h00};
        model_packet(p, r);
        check("pin_div_res", r, 32'h14);
        alu_res       = r;
        alu_res_valid = 1'b1;
        send_pkt(p);
        wait_res_hs(2'd2);
        wait_drain("div");

        p = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02};
        send_pkt(p);
        @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        p = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h11};
        model_packet(p, r);
        send_pkt(p);
        wait_drain("after_reset");

        p = '{8'h77, 8'h00, 8'h04, 8'h00};
        model_packet(p, r);
        send_pkt(p);
        @(negedge clk);
        check("unknown_err_pulse", err_o, 1);
        check("unknown_not_busy", busy_o, 0);
        @(posedge clk);
        #1;
        wait_drain("unknown");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
